// File: rtl/tcp_tx_packetizer_pkg.sv
// Shared types and constants for the TCP TX packetizer: status codes,
// request/completion records and the packetizer FSM state encoding.
package tcp_tx_packetizer_pkg;

    localparam int PKT_SID_BITS = 16;
    localparam int PKT_LEN_BITS = 32;

    // TX status / completion error codes
    localparam logic [1:0] TCP_ERR_OK     = 2'd0;
    localparam logic [1:0] TCP_ERR_RETRY  = 2'd1;
    localparam logic [1:0] TCP_ERR_CLOSED = 2'd2;
    localparam logic [1:0] TCP_ERR_FATAL  = 2'd3;

    typedef struct packed {
        logic [PKT_SID_BITS-1:0] sid;
        logic [PKT_LEN_BITS-1:0] len;
    } tcp_pkt_req_t;

    typedef struct packed {
        logic [PKT_SID_BITS-1:0] sid;
        logic [1:0]              err;
    } tcp_pkt_cmpl_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_META,
        ST_STAT,
        ST_WAIT,
        ST_DATA,
        ST_DRAIN,
        ST_CMPL
    } pkt_state_e;

endpackage

// File: rtl/tcp_tx_packetizer.sv
// Per-region TCP TX front end. Splits one user send request into packets of
// at most MAX_PKT bytes; each packet gets a meta request, waits for the stack's
// TX status, then streams its beats with a regenerated tlast. A retryable status
// backs off and reissues the meta; a fatal status drains the rest of the request.
module tcp_tx_packetizer #(
    parameter int DATA_BITS    = 512,
    parameter int SID_BITS     = 16,
    parameter int LEN_BITS     = 32,
    parameter int TCP_LEN_BITS = 16,
    parameter int MAX_PKT      = 4096,
    parameter int RETRY_WAIT   = 16
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    // user request
    input  logic                    s_req_valid,
    output logic                    s_req_ready,
    input  logic [SID_BITS-1:0]     s_req_sid,
    input  logic [LEN_BITS-1:0]     s_req_len,
    // packet meta to arbiter
    output logic                    m_tx_meta_valid,
    input  logic                    m_tx_meta_ready,
    output logic [SID_BITS-1:0]     m_tx_meta_sid,
    output logic [TCP_LEN_BITS-1:0] m_tx_meta_len,
    // TX status from stack
    input  logic                    s_tx_stat_valid,
    output logic                    s_tx_stat_ready,
    input  logic [SID_BITS-1:0]     s_tx_stat_sid,
    input  logic [1:0]              s_tx_stat_err,
    // user data
    input  logic [DATA_BITS-1:0]    s_axis_tdata,
    input  logic [DATA_BITS/8-1:0]  s_axis_tkeep,
    input  logic                    s_axis_tvalid,
    output logic                    s_axis_tready,
    // packet data to arbiter
    output logic [DATA_BITS-1:0]    m_axis_tdata,
    output logic [DATA_BITS/8-1:0]  m_axis_tkeep,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic                    m_axis_tlast,
    // request completion
    output logic                    m_cmpl_valid,
    input  logic                    m_cmpl_ready,
    output logic [SID_BITS-1:0]     m_cmpl_sid,
    output logic [1:0]              m_cmpl_err
);
    import tcp_tx_packetizer_pkg::*;

    localparam int BYTES    = DATA_BITS / 8;
    localparam int BEAT_LOG = $clog2(BYTES);
    localparam int WAIT_W   = (RETRY_WAIT > 1) ? $clog2(RETRY_WAIT) : 1;
    localparam logic [WAIT_W-1:0]   WAIT_LAST = WAIT_W'(RETRY_WAIT - 1);
    localparam logic [LEN_BITS-1:0] MAX_PKT_L = LEN_BITS'(MAX_PKT);

    // Number of bus beats needed to carry n bytes.
    function automatic logic [LEN_BITS-1:0] beats_of(input logic [LEN_BITS-1:0] n);
        return (n >> BEAT_LOG) + LEN_BITS'(|n[BEAT_LOG-1:0]);
    endfunction

    pkt_state_e          state_q, state_d;
    logic [SID_BITS-1:0] sid_q, sid_d;
    logic [LEN_BITS-1:0] rem_q, rem_d;       // bytes of the request not yet sent
    logic [LEN_BITS-1:0] chunk_q, chunk_d;   // bytes in the current packet
    logic [LEN_BITS-1:0] beats_q, beats_d;   // beats in the current packet / drain
    logic [LEN_BITS-1:0] cnt_q, cnt_d;       // beats handled so far
    logic [1:0]          err_q, err_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic                meta_vld_q, meta_vld_d;

    logic       last_beat;
    logic [1:0] stat_code;

    assign last_beat = (cnt_q == beats_q - 1'b1);
    // A status for some other session means the stack is confused; treat it as fatal.
    assign stat_code = (s_tx_stat_sid != sid_q) ? TCP_ERR_FATAL : s_tx_stat_err;

    assign m_tx_meta_sid = sid_q;
    assign m_tx_meta_len = chunk_q[TCP_LEN_BITS-1:0];
    assign m_axis_tdata  = s_axis_tdata;
    assign m_axis_tkeep  = s_axis_tkeep;
    assign m_cmpl_sid    = sid_q;
    assign m_cmpl_err    = err_q;

    // Next-state, datapath updates and handshake outputs.
    always_comb begin
        // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latch).
        state_d         = state_q;
        sid_d           = sid_q;
        rem_d           = rem_q;
        chunk_d         = chunk_q;
        beats_d         = beats_q;
        cnt_d           = cnt_q;
        err_d           = err_q;
        wait_d          = wait_q;
        meta_vld_d      = meta_vld_q;
        s_req_ready     = 1'b0;
        m_tx_meta_valid = 1'b0;
        s_tx_stat_ready = 1'b0;
        s_axis_tready   = 1'b0;
        m_axis_tvalid   = 1'b0;
        m_axis_tlast    = 1'b0;
        m_cmpl_valid    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                s_req_ready = 1'b1;
                if (s_req_valid) begin
                    sid_d      = s_req_sid;
                    rem_d      = s_req_len;
                    err_d      = TCP_ERR_OK;
                    meta_vld_d = 1'b0;
                    state_d    = (s_req_len == '0) ? ST_CMPL : ST_META;
                end
            end
            ST_META: begin
                // First cycle registers the chunk; meta is offered from the next one.
                if (!meta_vld_q) begin
                    chunk_d    = (rem_q > MAX_PKT_L) ? MAX_PKT_L : rem_q;
                    meta_vld_d = 1'b1;
                end else begin
                    m_tx_meta_valid = 1'b1;
                    if (m_tx_meta_ready) begin
                        meta_vld_d = 1'b0;
                        state_d    = ST_STAT;
                    end
                end
            end
            ST_STAT: begin
                s_tx_stat_ready = 1'b1;
                if (s_tx_stat_valid) begin
                    cnt_d = '0;
                    if (stat_code == TCP_ERR_OK) begin
                        beats_d = beats_of(chunk_q);
                        state_d = ST_DATA;
                    end else if (stat_code == TCP_ERR_RETRY) begin
                        wait_d  = '0;
                        state_d = ST_WAIT;
                    end else begin
                        // The current packet was never sent, so drain everything left.
                        err_d   = stat_code;
                        beats_d = beats_of(rem_q);
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_WAIT: begin
                if (wait_q == WAIT_LAST) begin
                    state_d = ST_META;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            ST_DATA: begin
                m_axis_tvalid = s_axis_tvalid;
                s_axis_tready = m_axis_tready;
                m_axis_tlast  = last_beat;
                if (s_axis_tvalid && m_axis_tready) begin
                    if (last_beat) begin
                        cnt_d   = '0;
                        rem_d   = rem_q - chunk_q;
                        state_d = (rem_q == chunk_q) ? ST_CMPL : ST_META;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                s_axis_tready = 1'b1;
                if (s_axis_tvalid) begin
                    if (last_beat) begin
                        state_d = ST_CMPL;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_CMPL: begin
                m_cmpl_valid = 1'b1;
                if (m_cmpl_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any request in flight.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q    <= ST_IDLE;
            sid_q      <= '0;
            rem_q      <= '0;
            chunk_q    <= '0;
            beats_q    <= '0;
            cnt_q      <= '0;
            err_q      <= TCP_ERR_OK;
            wait_q     <= '0;
            meta_vld_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q    <= state_d;
            sid_q      <= sid_d;
            rem_q      <= rem_d;
            chunk_q    <= chunk_d;
            beats_q    <= beats_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            wait_q     <= wait_d;
            meta_vld_q <= meta_vld_d;
        end
    end

endmodule

// File: tb/tb_tcp_tx_packetizer.sv
// Self-checking bench for tcp_tx_packetizer: a table of requests with expected
// packet/beat counts, plus hand-written retry, drain, sid-mismatch, random
// backpressure and mid-transfer reset sequences. Expected metas, beats and
// completions are pushed to scoreboard queues when a request is set up.
module tb_tcp_tx_packetizer;
    import tcp_tx_packetizer_pkg::*;

    localparam int DATA_BITS    = 512;
    localparam int BYTES        = DATA_BITS / 8;
    localparam int SID_BITS     = 16;
    localparam int LEN_BITS     = 32;
    localparam int TCP_LEN_BITS = 16;
    localparam int MAX_PKT      = 4096;
    localparam int RETRY_WAIT   = 16;
    localparam logic [LEN_BITS-1:0] MAX_L = 32'd4096;

    typedef logic [DATA_BITS-1:0] word_t;

    typedef struct {
        logic [DATA_BITS-1:0] data;
        logic [BYTES-1:0]     keep;
        logic                 last;
    } beat_t;

    typedef struct {
        logic [SID_BITS-1:0] sid;
        logic [LEN_BITS-1:0] len;
        int                  exp_metas;
        int                  exp_beats;
        logic [1:0]          exp_err;
    } req_vec_t;

    logic                    aclk;
    logic                    aresetn;
    logic                    s_req_valid, s_req_ready;
    logic [SID_BITS-1:0]     s_req_sid;
    logic [LEN_BITS-1:0]     s_req_len;
    logic                    m_tx_meta_valid, m_tx_meta_ready;
    logic [SID_BITS-1:0]     m_tx_meta_sid;
    logic [TCP_LEN_BITS-1:0] m_tx_meta_len;
    logic                    s_tx_stat_valid, s_tx_stat_ready;
    logic [SID_BITS-1:0]     s_tx_stat_sid;
    logic [1:0]              s_tx_stat_err;
    logic [DATA_BITS-1:0]    s_axis_tdata, m_axis_tdata;
    logic [BYTES-1:0]        s_axis_tkeep, m_axis_tkeep;
    logic                    s_axis_tvalid, s_axis_tready;
    logic                    m_axis_tvalid, m_axis_tready, m_axis_tlast;
    logic                    m_cmpl_valid, m_cmpl_ready;
    logic [SID_BITS-1:0]     m_cmpl_sid;
    logic [1:0]              m_cmpl_err;

    tcp_tx_packetizer #(
        .DATA_BITS(DATA_BITS), .SID_BITS(SID_BITS), .LEN_BITS(LEN_BITS),
        .TCP_LEN_BITS(TCP_LEN_BITS), .MAX_PKT(MAX_PKT), .RETRY_WAIT(RETRY_WAIT)
    ) dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_req_valid(s_req_valid), .s_req_ready(s_req_ready),
        .s_req_sid(s_req_sid), .s_req_len(s_req_len),
        .m_tx_meta_valid(m_tx_meta_valid), .m_tx_meta_ready(m_tx_meta_ready),
        .m_tx_meta_sid(m_tx_meta_sid), .m_tx_meta_len(m_tx_meta_len),
        .s_tx_stat_valid(s_tx_stat_valid), .s_tx_stat_ready(s_tx_stat_ready),
        .s_tx_stat_sid(s_tx_stat_sid), .s_tx_stat_err(s_tx_stat_err),
        .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tlast(m_axis_tlast),
        .m_cmpl_valid(m_cmpl_valid), .m_cmpl_ready(m_cmpl_ready),
        .m_cmpl_sid(m_cmpl_sid), .m_cmpl_err(m_cmpl_err)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // scoreboard queues
    beat_t                   src_q[$];
    beat_t                   exp_beat_q[$];
    logic [TCP_LEN_BITS-1:0] exp_meta_q[$];
    logic [2:0]              stat_q[$];      // {corrupt sid, err}
    tcp_pkt_cmpl_t           exp_cmpl_q[$];

    // counters and bfm state
    int n_checks = 0;
    int n_fail   = 0;
    int cycle = 0, meta_seen = 0, beats_seen = 0, cmpl_seen = 0, tvalid_hi = 0;
    int retry_stat_cyc = 0, retry_beats = 0, seq_base = 0;
    int meta_cycs[$];
    int meta_beats[$];
    logic [1:0]              last_cmpl_err = 2'd0;
    logic [SID_BITS-1:0]     meta_sid_seen = '0;
    logic                    rand_mode = 1'b0;
    logic                    stat_pend = 1'b0, meta_stall = 1'b0;
    logic                    in_taken = 1'b0, stat_taken = 1'b0;
    logic [TCP_LEN_BITS-1:0] stall_len = '0;

    task automatic check(input string name, input word_t act, input word_t exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [DATA_BITS-1:0] make_data(input int k);
        logic [DATA_BITS-1:0] d;
        for (int i = 0; i < DATA_BITS / 32; i++) d[i*32 +: 32] = 32'(k) * 32'h9E3779B1 + 32'(i);
        return d;
    endfunction

    function automatic logic [BYTES-1:0] keep_of(input int idx, input int tot, input logic [LEN_BITS-1:0] len);
        if (idx == tot - 1 && len[5:0] != 6'd0) return (64'd1 << len[5:0]) - 64'd1;
        return '1;
    endfunction

    // Push source beats and all expected metas, statuses, output beats and the completion.
    task automatic setup_req(input logic [SID_BITS-1:0] sid, input logic [LEN_BITS-1:0] len,
                             input int retry_pkt, input int fatal_pkt, input logic [2:0] fatal_stat);
        logic [LEN_BITS-1:0] rem, chunk;
        int tot, pb, b, pkt;
        logic [1:0] cerr;
        beat_t bt;
        tcp_pkt_cmpl_t c;
        tot = int'(len >> 6) + int'(len[5:0] != 6'd0);
        for (int i = 0; i < tot; i++) begin
            bt.data = make_data(seq_base + i);
            bt.keep = keep_of(i, tot, len);
            bt.last = 1'b0;
            src_q.push_back(bt);
        end
        rem = len; pkt = 0; b = 0; cerr = TCP_ERR_OK;
        while (rem != '0) begin
            chunk = (rem > MAX_L) ? MAX_L : rem;
            exp_meta_q.push_back(chunk[TCP_LEN_BITS-1:0]);
            if (pkt == retry_pkt) begin
                stat_q.push_back({1'b0, TCP_ERR_RETRY});
                exp_meta_q.push_back(chunk[TCP_LEN_BITS-1:0]);
            end
            if (pkt == fatal_pkt) begin
                stat_q.push_back(fatal_stat);
                cerr = fatal_stat[2] ? TCP_ERR_FATAL : fatal_stat[1:0];
                break;
            end
            stat_q.push_back(3'b000);
            pb = int'((chunk + 32'd63) >> 6);
            for (int j = 0; j < pb; j++) begin
                bt.data = make_data(seq_base + b + j);
                bt.keep = keep_of(b + j, tot, len);
                bt.last = (j == pb - 1);
                exp_beat_q.push_back(bt);
            end
            b   += pb;
            rem -= chunk;
            pkt++;
        end
        c.sid = sid;
        c.err = cerr;
        exp_cmpl_q.push_back(c);
        seq_base += tot;
    endtask

    task automatic send_req(input logic [SID_BITS-1:0] sid, input logic [LEN_BITS-1:0] len);
        int n = 0;
        @(posedge aclk); #1;
        s_req_valid = 1'b1; s_req_sid = sid; s_req_len = len;
        @(negedge aclk);
        while (!s_req_ready && n < 1000) begin @(negedge aclk); n++; end
        if (!s_req_ready) check("req_ready_timeout", word_t'(0), word_t'(1));
        @(posedge aclk); #1;
        s_req_valid = 1'b0;
    endtask

    task automatic wait_cmpl(input int target, input string name);
        int n = 0;
        while (cmpl_seen < target && n < 20000) begin @(posedge aclk); n++; end
        if (cmpl_seen < target) check({name, "_timeout"}, word_t'(cmpl_seen), word_t'(target));
        @(negedge aclk);
    endtask

    task automatic check_drained(input string name);
        check({name, "_beats_left"}, word_t'(exp_beat_q.size()), word_t'(0));
        check({name, "_metas_left"}, word_t'(exp_meta_q.size()), word_t'(0));
        check({name, "_src_left"}, word_t'(src_q.size()), word_t'(0));
    endtask

    // Bus functional model: drives stack/sink/source inputs after each rising
    // edge and scores DUT outputs on the falling edge.
    initial begin : bfm
        logic [2:0] st;
        beat_t e;
        tcp_pkt_cmpl_t c;
        forever begin
            @(posedge aclk); #1;
            cycle++;
            m_tx_meta_ready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
            m_axis_tready   = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
            m_cmpl_ready    = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
            if (stat_taken) begin s_tx_stat_valid = 1'b0; stat_taken = 1'b0; end
            if (stat_pend && !s_tx_stat_valid) begin
                st = (stat_q.size() > 0) ? stat_q.pop_front() : 3'b000;
                s_tx_stat_valid = 1'b1;
                s_tx_stat_err   = st[1:0];
                s_tx_stat_sid   = st[2] ? (meta_sid_seen ^ 16'd1) : meta_sid_seen;
            end
            if (in_taken) begin s_axis_tvalid = 1'b0; in_taken = 1'b0; end
            if (!s_axis_tvalid && src_q.size() > 0 && (!rand_mode || $urandom_range(0, 1) == 1)) begin
                s_axis_tdata  = src_q[0].data;
                s_axis_tkeep  = src_q[0].keep;
                s_axis_tvalid = 1'b1;
            end

            @(negedge aclk);
            if (s_axis_tvalid && s_axis_tready) begin
                void'(src_q.pop_front());
                in_taken = 1'b1;
            end
            if (m_axis_tvalid) tvalid_hi++;
            if (m_axis_tvalid && m_axis_tready) begin
                beats_seen++;
                if (exp_beat_q.size() == 0) begin
                    check("unexpected_beat", word_t'(1), word_t'(0));
                end else begin
                    e = exp_beat_q.pop_front();
                    check("beat_data", m_axis_tdata, e.data);
                    check("beat_keep", word_t'(m_axis_tkeep), word_t'(e.keep));
                    check("beat_last", word_t'(m_axis_tlast), word_t'(e.last));
                end
            end
            if (m_tx_meta_valid) begin
                if (meta_stall) check("meta_stable", word_t'(m_tx_meta_len), word_t'(stall_len));
                if (m_tx_meta_ready) begin
                    meta_seen++;
                    meta_cycs.push_back(cycle);
                    meta_beats.push_back(beats_seen);
                    meta_sid_seen = m_tx_meta_sid;
                    if (exp_cmpl_q.size() > 0)
                        check("meta_sid", word_t'(m_tx_meta_sid), word_t'(exp_cmpl_q[0].sid));
                    if (exp_meta_q.size() == 0) check("unexpected_meta", word_t'(1), word_t'(0));
                    else check("meta_len", word_t'(m_tx_meta_len), word_t'(exp_meta_q.pop_front()));
                    stat_pend  = 1'b1;
                    meta_stall = 1'b0;
                end else begin
                    meta_stall = 1'b1;
                    stall_len  = m_tx_meta_len;
                end
            end else if (meta_stall) begin
                check("meta_held", word_t'(0), word_t'(1));
                meta_stall = 1'b0;
            end
            if (s_tx_stat_valid && s_tx_stat_ready) begin
                stat_taken = 1'b1;
                stat_pend  = 1'b0;
                if (s_tx_stat_err == TCP_ERR_RETRY) begin
                    retry_stat_cyc = cycle;
                    retry_beats    = beats_seen;
                end
            end
            if (m_cmpl_valid && m_cmpl_ready) begin
                cmpl_seen++;
                last_cmpl_err = m_cmpl_err;
                if (exp_cmpl_q.size() == 0) begin
                    check("unexpected_cmpl", word_t'(1), word_t'(0));
                end else begin
                    c = exp_cmpl_q.pop_front();
                    check("cmpl_sid", word_t'(m_cmpl_sid), word_t'(c.sid));
                    check("cmpl_err", word_t'(m_cmpl_err), word_t'(c.err));
                end
            end
        end
    end

    initial begin : main
        req_vec_t vecs[7];
        int m0, b0, c0, t0, n;

        vecs[0] = '{16'd5,  32'd10000, 3, 157, TCP_ERR_OK};
        vecs[1] = '{16'd7,  32'd64,    1, 1,   TCP_ERR_OK};
        vecs[2] = '{16'd11, 32'd4096,  1, 64,  TCP_ERR_OK};
        vecs[3] = '{16'd12, 32'd4097,  2, 65,  TCP_ERR_OK};
        vecs[4] = '{16'd13, 32'd1,     1, 1,   TCP_ERR_OK};
        vecs[5] = '{16'd14, 32'd5000,  2, 79,  TCP_ERR_OK};
        vecs[6] = '{16'd15, 32'd8191,  2, 128, TCP_ERR_OK};

        aresetn = 1'b0;
        s_req_valid = 1'b0; s_req_sid = '0; s_req_len = '0;
        s_tx_stat_valid = 1'b0; s_tx_stat_sid = '0; s_tx_stat_err = '0;
        s_axis_tvalid = 1'b0; s_axis_tdata = '0; s_axis_tkeep = '0;
        m_tx_meta_ready = 1'b0; m_axis_tready = 1'b0; m_cmpl_ready = 1'b0;

        // reset state
        repeat (3) @(negedge aclk);
        check("rst_req_ready",   word_t'(s_req_ready),     word_t'(1));
        check("rst_meta_valid",  word_t'(m_tx_meta_valid), word_t'(0));
        check("rst_stat_ready",  word_t'(s_tx_stat_ready), word_t'(0));
        check("rst_axis_tready", word_t'(s_axis_tready),   word_t'(0));
        check("rst_axis_tvalid", word_t'(m_axis_tvalid),   word_t'(0));
        check("rst_cmpl_valid",  word_t'(m_cmpl_valid),    word_t'(0));
        aresetn = 1'b1;

        // table of all-ok requests
        for (int i = 0; i < 7; i++) begin
            m0 = meta_seen; b0 = beats_seen; c0 = cmpl_seen;
            setup_req(vecs[i].sid, vecs[i].len, -1, -1, 3'b000);
            send_req(vecs[i].sid, vecs[i].len);
            wait_cmpl(c0 + 1, "vec");
            check("vec_metas", word_t'(meta_seen - m0),  word_t'(vecs[i].exp_metas));
            check("vec_beats", word_t'(beats_seen - b0), word_t'(vecs[i].exp_beats));
            check("vec_err",   word_t'(last_cmpl_err),   word_t'(vecs[i].exp_err));
            check_drained("vec");
        end

        // zero-length request completes on the very next cycle with no meta
        m0 = meta_seen; c0 = cmpl_seen;
        setup_req(16'd6, 32'd0, -1, -1, 3'b000);
        send_req(16'd6, 32'd0);
        check("len0_cmpl_next", word_t'(m_cmpl_valid), word_t'(1));
        wait_cmpl(c0 + 1, "len0");
        check("len0_no_meta", word_t'(meta_seen - m0), word_t'(0));

        // retry on the second packet: back-off, same meta reissued, then data
        m0 = meta_seen; b0 = beats_seen; c0 = cmpl_seen;
        meta_cycs.delete(); meta_beats.delete();
        setup_req(16'd8, 32'd8192, 1, -1, 3'b000);
        send_req(16'd8, 32'd8192);
        wait_cmpl(c0 + 1, "retry");
        check("retry_metas", word_t'(meta_seen - m0),  word_t'(3));
        check("retry_beats", word_t'(beats_seen - b0), word_t'(128));
        if (meta_cycs.size() == 3) begin
            // RETRY_WAIT back-off cycles, one ST_META entry cycle, handshake on the first valid cycle
            check("retry_gap",   word_t'(meta_cycs[2] - retry_stat_cyc), word_t'(RETRY_WAIT + 2));
            check("retry_quiet", word_t'(meta_beats[2]), word_t'(retry_beats));
        end else begin
            check("retry_meta_count", word_t'(meta_cycs.size()), word_t'(3));
        end
        check_drained("retry");

        // closed on the first status: whole request drained, nothing forwarded
        t0 = tvalid_hi; b0 = beats_seen; c0 = cmpl_seen;
        setup_req(16'd9, 32'd8192, -1, 0, {1'b0, TCP_ERR_CLOSED});
        send_req(16'd9, 32'd8192);
        wait_cmpl(c0 + 1, "closed");
        check("closed_no_tvalid", word_t'(tvalid_hi - t0), word_t'(0));
        check("closed_no_beats",  word_t'(beats_seen - b0), word_t'(0));
        check("closed_err",       word_t'(last_cmpl_err), word_t'(TCP_ERR_CLOSED));
        check_drained("closed");

        // echoed sid mismatch on the second packet counts as fatal
        b0 = beats_seen; c0 = cmpl_seen;
        setup_req(16'd10, 32'd4160, -1, 1, 3'b100);
        send_req(16'd10, 32'd4160);
        wait_cmpl(c0 + 1, "sidbad");
        check("sidbad_beats", word_t'(beats_seen - b0), word_t'(64));
        check("sidbad_err",   word_t'(last_cmpl_err), word_t'(TCP_ERR_FATAL));
        check_drained("sidbad");

        // random backpressure on every handshake
        rand_mode = 1'b1;
        m0 = meta_seen; b0 = beats_seen; c0 = cmpl_seen;
        setup_req(16'd20, 32'd5000, -1, -1, 3'b000);
        send_req(16'd20, 32'd5000);
        wait_cmpl(c0 + 1, "rand");
        rand_mode = 1'b0;
        check("rand_metas", word_t'(meta_seen - m0),  word_t'(2));
        check("rand_beats", word_t'(beats_seen - b0), word_t'(79));
        check_drained("rand");

        // reset in the middle of the data phase aborts silently
        b0 = beats_seen; c0 = cmpl_seen;
        setup_req(16'd30, 32'd8192, -1, -1, 3'b000);
        send_req(16'd30, 32'd8192);
        n = 0;
        while (beats_seen - b0 < 30 && n < 2000) begin @(negedge aclk); n++; end
        check("mid_beats_reached", word_t'(beats_seen - b0 >= 30), word_t'(1));
        @(posedge aclk); #3;
        aresetn = 1'b0;
        #1;
        check("arst_meta_valid",  word_t'(m_tx_meta_valid), word_t'(0));
        check("arst_axis_tvalid", word_t'(m_axis_tvalid),   word_t'(0));
        check("arst_cmpl_valid",  word_t'(m_cmpl_valid),    word_t'(0));
        check("arst_stat_ready",  word_t'(s_tx_stat_ready), word_t'(0));
        check("arst_axis_tready", word_t'(s_axis_tready),   word_t'(0));
        src_q.delete(); exp_beat_q.delete(); exp_meta_q.delete();
        stat_q.delete(); exp_cmpl_q.delete();
        s_axis_tvalid = 1'b0; s_tx_stat_valid = 1'b0;
        stat_pend = 1'b0; meta_stall = 1'b0; in_taken = 1'b0; stat_taken = 1'b0;
        repeat (3) @(negedge aclk);
        aresetn = 1'b1;
        @(negedge aclk);
        check("post_rst_req_ready", word_t'(s_req_ready), word_t'(1));
        check("post_rst_no_cmpl",   word_t'(cmpl_seen),   word_t'(c0));
        b0 = beats_seen;
        setup_req(16'd31, 32'd128, -1, -1, 3'b000);
        send_req(16'd31, 32'd128);
        wait_cmpl(c0 + 1, "post_rst");
        check("post_rst_beats", word_t'(beats_seen - b0), word_t'(2));
        check_drained("post_rst");

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
